// File: rtl/freq_gate_counter.sv
// Gated edge counter for the frequency meter: counts rising edges of clk_x_in per gate
// window, then converts the count to packed BCD with a serial double-dabble engine.
module freq_gate_counter #(
   parameter int GATE_CYCLES = 1000000,
   parameter int CNT_WIDTH   = 24,
   parameter int DIGITS      = 8
) (
   input  logic                  clk_ref_in,
   input  logic                  resetn_in,
   input  logic                  clk_x_in,
   output logic [4*DIGITS-1:0]   result_bcd_out,
   output logic                  result_valid_out,
   output logic                  overflow_out,
   output logic                  gate_out
);

   localparam int GW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int BW    = $clog2(CNT_WIDTH + 1);
   localparam int BCD_W = 4 * DIGITS;
   localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [BCD_W-1:0]     ALL_NINES = {DIGITS{4'h9}};

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   logic                 sync1_reg, sync2_reg, sync3_reg;
   logic                 edge_det;
   logic [GW-1:0]        gate_cnt_reg;
   logic                 terminal;
   logic [CNT_WIDTH-1:0] edge_cnt_reg;
   logic                 ovf_reg;
   logic                 gate_reg;
   logic                 edge_at_max;
   logic [CNT_WIDTH-1:0] snap_cnt;
   logic                 snap_ovf;
   logic                 snap_ovf_reg;
   logic [CNT_WIDTH-1:0] shift_reg;
   logic [BCD_W-1:0]     bcd_reg;
   logic [BCD_W-1:0]     bcd_adj;
   logic [BW-1:0]        bit_cnt_reg;
   state_t               state_reg, state_next;
   logic [BCD_W-1:0]     result_bcd_reg;
   logic                 result_valid_reg;
   logic                 result_ovf_reg;

   always_ff @(posedge clk_ref_in or negedge resetn_in) begin
      if (!resetn_in) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         sync3_reg <= 1'b0;
      end else begin
         sync1_reg <= clk_x_in;
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg;
      end
   end

   assign edge_det    = sync2_reg & ~sync3_reg;
   assign terminal    = (gate_cnt_reg == GATE_LAST);
   assign edge_at_max = edge_det & (edge_cnt_reg == CNT_MAX);

   // An edge landing in the terminal cycle still belongs to the window being closed.
   always_comb begin
      snap_cnt = edge_cnt_reg;
      if (edge_det && !edge_at_max)
         snap_cnt = edge_cnt_reg + CNT_WIDTH'(1);
   end
   assign snap_ovf = ovf_reg | edge_at_max;

   always_ff @(posedge clk_ref_in or negedge resetn_in) begin
      if (!resetn_in) begin
         gate_cnt_reg <= '0;
         edge_cnt_reg <= '0;
         ovf_reg      <= 1'b0;
         gate_reg     <= 1'b0;
      end else if (terminal) begin
         gate_cnt_reg <= '0;
         edge_cnt_reg <= '0;
         ovf_reg      <= 1'b0;
         gate_reg     <= ~gate_reg;
      end else begin
         gate_cnt_reg <= gate_cnt_reg + GW'(1);
         if (edge_at_max)
            ovf_reg <= 1'b1;
         else if (edge_det)
            edge_cnt_reg <= edge_cnt_reg + CNT_WIDTH'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                     bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge clk_ref_in or negedge resetn_in) begin
      if (!resetn_in)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (terminal) state_next = ST_SHIFT;
         ST_SHIFT: if (bit_cnt_reg == BW'(1)) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // The shift register is loaded straight from the snapshot value so SHIFT starts at T+1.
   always_ff @(posedge clk_ref_in or negedge resetn_in) begin
      if (!resetn_in) begin
         shift_reg        <= '0;
         bcd_reg          <= '0;
         bit_cnt_reg      <= '0;
         snap_ovf_reg     <= 1'b0;
         result_bcd_reg   <= '0;
         result_valid_reg <= 1'b0;
         result_ovf_reg   <= 1'b0;
      end else begin
         result_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (terminal) begin
                  shift_reg    <= snap_cnt;
                  bcd_reg      <= '0;
                  bit_cnt_reg  <= BW'(CNT_WIDTH);
                  snap_ovf_reg <= snap_ovf;
               end
            end
            ST_SHIFT: begin
               bcd_reg     <= {bcd_adj[BCD_W-2:0], shift_reg[CNT_WIDTH-1]};
               shift_reg   <= {shift_reg[CNT_WIDTH-2:0], 1'b0};
               bit_cnt_reg <= bit_cnt_reg - BW'(1);
            end
            ST_DONE: begin
               result_bcd_reg   <= snap_ovf_reg ? ALL_NINES : bcd_reg;
               result_ovf_reg   <= snap_ovf_reg;
               result_valid_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign result_bcd_out   = result_bcd_reg;
   assign result_valid_out = result_valid_reg;
   assign overflow_out     = result_ovf_reg;
   assign gate_out         = gate_reg;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Randomized bench for freq_gate_counter: a wide instance and a narrow saturating instance
// share one stimulus; expected results come from per-window rise counts.
module tb_freq_gate_counter;

   localparam int G   = 100;
   localparam int W_A = 24;
   localparam int D_A = 8;
   localparam int W_B = 4;
   localparam int D_B = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        x;
   logic [31:0] bcd_a;
   logic        valid_a, ovf_a, gate_a;
   logic [7:0]  bcd_b;
   logic        valid_b, ovf_b, gate_b;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc;
   int          mode;
   int          phase_left;
   int          win_cnt [0:63];
   logic [31:0] held_bcd [0:1];
   logic        held_ovf [0:1];

   always #5 clk = ~clk;

   freq_gate_counter #(.GATE_CYCLES(G), .CNT_WIDTH(W_A), .DIGITS(D_A)) dut_a (
      .clk_ref_in(clk), .resetn_in(resetn), .clk_x_in(x),
      .result_bcd_out(bcd_a), .result_valid_out(valid_a),
      .overflow_out(ovf_a), .gate_out(gate_a)
   );

   freq_gate_counter #(.GATE_CYCLES(G), .CNT_WIDTH(W_B), .DIGITS(D_B)) dut_b (
      .clk_ref_in(clk), .resetn_in(resetn), .clk_x_in(x),
      .result_bcd_out(bcd_b), .result_valid_out(valid_b),
      .overflow_out(ovf_b), .gate_out(gate_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] to_bcd(input int v, input int d);
      logic [31:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Window k closes at cycle (k+1)G-1; its result is visible w+2 cycles later.
   task automatic check_dut(input int id, input int w, input int d,
                            input logic [31:0] bcd, input logic valid,
                            input logic ovf, input logic gate);
      string nm;
      bit    strobe;
      int    k, c, maxv;
      nm     = (id == 0) ? "A" : "B";
      maxv   = (1 << w) - 1;
      strobe = (cyc >= G + w + 1) && (((cyc - w - 1) % G) == 0);
      if (strobe) begin
         k = (cyc - w - 1) / G - 1;
         c = (k < 64) ? win_cnt[k] : 0;
         held_ovf[id] = (c > maxv);
         held_bcd[id] = held_ovf[id] ? to_bcd(10 ** d - 1, d) : to_bcd(c, d);
         $display("%s window %0d: rises %0d -> bcd %h ovf %0b (cycle %0d)",
                  nm, k, c, held_bcd[id], held_ovf[id], cyc);
      end
      check($sformatf("%s valid c%0d", nm, cyc), 32'(valid), 32'(strobe));
      check($sformatf("%s bcd c%0d", nm, cyc), bcd, held_bcd[id]);
      check($sformatf("%s ovf c%0d", nm, cyc), 32'(ovf), 32'(held_ovf[id]));
      check($sformatf("%s gate c%0d", nm, cyc), 32'(gate), 32'((cyc / G) % 2));
   endtask

   function automatic int pick_len(input int m);
      case (m)
         1:       return 5;
         2:       return 1;
         3:       return ($urandom_range(0, 99) < 65) ? 1 : 2;
         4:       return $urandom_range(8, 20);
         default: return 1;
      endcase
   endfunction

   // A rise applied during cycle n is seen by the edge detector in cycle n+2.
   task automatic step();
      logic nx;
      int   idx;
      check_dut(0, W_A, D_A, bcd_a, valid_a, ovf_a, gate_a);
      check_dut(1, W_B, D_B, 32'(bcd_b), valid_b, ovf_b, gate_b);
      if (mode == 0) begin
         nx = 1'b0;
      end else if (phase_left <= 1) begin
         nx = ~x;
         phase_left = pick_len(mode);
      end else begin
         nx = x;
         phase_left--;
      end
      if (nx && !x) begin
         idx = (cyc + 2) / G;
         if (idx < 64) win_cnt[idx]++;
      end
      x = nx;
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int m, input int n);
      mode = m;
      phase_left = 1;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_model();
      for (int i = 0; i < 64; i++) win_cnt[i] = 0;
      held_bcd[0] = '0; held_bcd[1] = '0;
      held_ovf[0] = 1'b0; held_ovf[1] = 1'b0;
      cyc = 0;
      phase_left = 1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " A bcd"}, bcd_a, 32'h0);
      check({tag, " A valid"}, 32'(valid_a), 32'h0);
      check({tag, " A ovf"}, 32'(ovf_a), 32'h0);
      check({tag, " A gate"}, 32'(gate_a), 32'h0);
      check({tag, " B bcd"}, 32'(bcd_b), 32'h0);
      check({tag, " B valid"}, 32'(valid_b), 32'h0);
      check({tag, " B ovf"}, 32'(ovf_b), 32'h0);
      check({tag, " B gate"}, 32'(gate_b), 32'h0);
   endtask

   initial begin
      resetn = 1'b0;
      x      = 1'b0;
      mode   = 0;
      clear_model();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      resetn = 1'b1;

      run(1, 450);   // ref/10: ten rises per window
      run(0, 300);   // static input
      run(2, 300);   // ref/2: fifty rises, narrow instance saturates
      run(3, 600);   // ~0.37x ref with random phase jitter
      run(4, 500);   // slow input, narrow instance leaves overflow

      mode = 3;
      phase_left = 1;
      while (!(cyc >= 2 * G && (cyc % G) == 4)) step();
      resetn = 1'b0;
      #1;
      check_all_zero("midconv");
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check(  "midconv A valid held", 32'(valid_a), 32'h0);
         check(  "midconv B valid held", 32'(valid_b), 32'h0);
      end
      x = 1'b0;
      clear_model();
      resetn = 1'b1;

      run(1, 400);
      run(3, 400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
